sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-ported synchronous SRAM between the core's instruction-fetch and data-access requesters.
//  Sits between mycpu_core and a unified SRAM: core-side ports mirror the inst_sram/data_sram request
//  shape; memory side is one sram_* port with fixed 1-cycle read latency.
//  Fixed data-over-inst priority, with a starvation guard that forces an instruction grant after
//  STARVE_LIMIT consecutive losses. Fully pipelined: one access issued per cycle, responses in order.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive lost arbitration cycles after which inst_req beats data_req (>=1)
//  CNT_W         3  starvation counter width; must satisfy 2**CNT_W > STARVE_LIMIT
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous reset, active-high
//  inst_req     in   1   fetch request (read-only), held by requester until granted
//  inst_addr    in   32  fetch byte address
//  inst_gnt     out  1   fetch issued to SRAM this cycle (combinational)
//  inst_rvalid  out  1   fetch data valid this cycle (registered owner flag)
//  inst_rdata   out  32  fetch data; sram_rdata when inst_rvalid else 0
//  data_req     in   1   data request, held until granted
//  data_wen     in   4   byte write enables; 4'b0000 = read
//  data_addr    in   32  data byte address
//  data_wdata   in   32  store data
//  data_gnt     out  1   data access issued this cycle (combinational)
//  data_rvalid  out  1   data response: read data or write ack
//  data_rdata   out  32  sram_rdata on read response; 0 on write ack or when data_rvalid=0
//  sram_en      out  1   shared SRAM enable
//  sram_wen     out  4   shared SRAM byte write enables
//  sram_addr    out  32  shared SRAM address
//  sram_wdata   out  32  shared SRAM write data
//  sram_rdata   in   32  SRAM read data, valid 1 cycle after sram_en with sram_wen=0
// BEHAVIOUR
//  Reset: starve_cnt=0, resp_owner=NONE, resp_is_wr=0; so inst_rvalid=data_rvalid=0, rdata outputs 0.
//   While rst=1, inst_gnt=data_gnt=0 and sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0.
//  Arbitration (combinational, every cycle, rst=0):
//   - force_inst = (starve_cnt == STARVE_LIMIT).
//   - data_gnt = data_req & ~(inst_req & force_inst); inst_gnt = inst_req & ~data_gnt.
//   - At most one grant per cycle; no grant -> sram_en=0, sram_wen=0, addr/wdata=0.
//  Issue: winner drives sram_en=1, sram_addr; data winner also sram_wen=data_wen, sram_wdata=data_wdata;
//   inst winner drives sram_wen=0, sram_wdata=0.
//  Response (registered): at edge after grant resp_owner<=INST/DATA, resp_is_wr<=(data_wen!=0);
//   no grant -> resp_owner<=NONE. Exactly 1-cycle latency, so back-to-back grants give back-to-back
//   responses in issue order; no buffering, no backpressure from requesters on responses.
//  inst_rvalid=(resp_owner==INST); data_rvalid=(resp_owner==DATA) for reads and writes alike.
//  Starvation counter: inst_req & ~inst_gnt & data_gnt -> starve_cnt+1, saturating at STARVE_LIMIT;
//   inst_gnt or ~inst_req -> 0; otherwise hold. Counter never wraps.
//  Forced cycle: with STARVE_LIMIT=4 and both requests held high, grant pattern is D,D,D,D,I,D,D,D,D,I...
//  Requester drops req before grant: no access, no response, counter cleared; no error signalled.
//  Reset mid-operation: an access granted in the cycle before rst rises produces no rvalid; in-flight
//   response is discarded; first grant possible in the first cycle with rst=0.
//  Address/width: addresses passed through unmodified (no translation, no alignment check).
// TESTING
//  1 inst_req=1, inst_addr=0xBFC00000, data_req=0 -> same cycle inst_gnt=1, sram_en=1, sram_wen=0,
//    sram_addr=0xBFC00000; next cycle sram_rdata=0x3C1D8000 -> inst_rvalid=1, inst_rdata=0x3C1D8000.
//  2 inst_req & data_req (read, addr 0x80000010) same cycle -> data_gnt=1, inst_gnt=0; next cycle
//    data_rvalid=1 with sram_rdata, inst_gnt=1 (data_req dropped), starve_cnt back to 0 after.
//  3 both reqs held 10 cycles, STARVE_LIMIT=4 -> grants D,D,D,D,I,D,D,D,D,I; inst_rvalid in cycles 6,11.
//  4 data write wen=4'b0011, addr=0x80000004, wdata=0x12345678 -> sram_wen=0011, sram_wdata=0x12345678;
//    next cycle data_rvalid=1, data_rdata=0 (ack), inst_rvalid=0.
//  5 inst granted in cycle N, rst=1 in cycle N+1 -> inst_rvalid=0 in N+1 and N+2, all sram_* = 0 while
//    rst=1; after rst falls, fresh inst_req granted first cycle.
//  6 alternating grants I,D,I,D with distinct sram_rdata each cycle -> each response routed to correct
//    requester one cycle later, no drops, no duplicates, other rdata output 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one 1-cycle-latency SRAM between fetch and data requesters
// Data wins by default; an instruction grant is forced after STARVE_LIMIT consecutive losses.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  owner_e           r_resp_owner;
  logic             r_resp_is_wr;
  logic [CNT_W-1:0] r_starve_cnt;

  logic w_force_inst;
  logic w_inst_gnt;
  logic w_data_gnt;

  always_comb begin
    w_force_inst = (r_starve_cnt == LIMIT);
    w_data_gnt   = ~rst & data_req & ~(inst_req & w_force_inst);
    w_inst_gnt   = ~rst & inst_req & ~w_data_gnt;
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    if (w_data_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (w_inst_gnt) begin
      sram_en   = 1'b1;
      sram_addr = inst_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_owner <= OWN_NONE;
      r_resp_is_wr <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      if (w_data_gnt) begin
        r_resp_owner <= OWN_DATA;
        r_resp_is_wr <= |data_wen;
      end else if (w_inst_gnt) begin
        r_resp_owner <= OWN_INST;
        r_resp_is_wr <= 1'b0;
      end else begin
        r_resp_owner <= OWN_NONE;
        r_resp_is_wr <= 1'b0;
      end

      // Saturates at LIMIT so the forced grant is held until the fetch actually wins
      if (w_inst_gnt || !inst_req) begin
        r_starve_cnt <= '0;
      end else if (w_data_gnt && (r_starve_cnt != LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  // Gating with rst drops a response whose grant preceded the reset edge
  always_comb begin
    inst_gnt    = w_inst_gnt;
    data_gnt    = w_data_gnt;
    inst_rvalid = ~rst & (r_resp_owner == OWN_INST);
    data_rvalid = ~rst & (r_resp_owner == OWN_DATA);
    inst_rdata  = inst_rvalid ? sram_rdata : 32'h0;
    data_rdata  = (data_rvalid && !r_resp_is_wr) ? sram_rdata : 32'h0;
  end

endmodule
